// File: rtl/pwm_level_decoder_if.sv
`default_nettype none
// pwm_level_decoder_if: PWM sample input plus the measured duty/level result bus.
interface pwm_level_decoder_if #(
  parameter int DW = 11
);
  logic          i_pwm;
  logic [DW-1:0] o_duty;
  logic          o_valid;
  logic [2:0]    o_level;
  logic          o_change;

  modport master (
    output i_pwm,
    input  o_duty,
    input  o_valid,
    input  o_level,
    input  o_change
  );

  modport slave (
    input  i_pwm,
    output o_duty,
    output o_valid,
    output o_level,
    output o_change
  );
endinterface
`default_nettype wire

// File: rtl/pwm_level_decoder.sv
`default_nettype none
// pwm_level_decoder: counts PWM high samples per window, reports duty and level 0..4.
// Define PWM_DEC_FILTER_EN to require two agreeing windows before o_level moves.
module pwm_level_decoder #(
  parameter int CLK_DIV = 100,
  parameter int PERIOD  = 1024,
  parameter int DW      = 11
) (
  input  logic               i_clk,
  input  logic               i_reset,
  pwm_level_decoder_if.slave bus
);

  localparam int c_tw = $clog2(CLK_DIV);
  localparam int c_ww = $clog2(PERIOD);
  localparam logic [c_tw-1:0] c_tick_last = c_tw'(CLK_DIV - 1);
  localparam logic [c_ww-1:0] c_win_last  = c_ww'(PERIOD - 1);
  localparam logic [DW-1:0]   c_q1        = DW'(PERIOD / 4);
  localparam logic [DW-1:0]   c_q2        = DW'(PERIOD / 2);
  localparam logic [DW-1:0]   c_q3        = DW'((3 * PERIOD) / 4);

  logic [1:0]      sync_q;
  logic [c_tw-1:0] tick_cnt_q, tick_cnt_d;
  logic [c_ww-1:0] win_cnt_q, win_cnt_d;
  logic [DW-1:0]   acc_q, acc_d;
  logic [DW-1:0]   duty_q, duty_d;
  logic            valid_q, valid_d;
  logic [2:0]      level_q, level_d;
  logic            change_q, change_d;

  logic            w_tick;
  logic            w_win_end;
  logic [DW-1:0]   w_duty;
  logic [2:0]      w_lvl;

  assign w_tick    = (tick_cnt_q == c_tick_last);
  assign w_win_end = w_tick && (win_cnt_q == c_win_last);
  // Running count including the sample taken this tick; at window end this is the duty.
  assign w_duty    = acc_q + {{(DW-1){1'b0}}, sync_q[1]};

  always_comb begin
    tick_cnt_d = w_tick ? '0 : tick_cnt_q + 1'b1;
    win_cnt_d  = win_cnt_q;
    acc_d      = acc_q;
    duty_d     = duty_q;
    valid_d    = 1'b0;
    if (w_tick) begin
      if (w_win_end) begin
        win_cnt_d = '0;
        acc_d     = '0;
        duty_d    = w_duty;
        valid_d   = 1'b1;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        acc_d     = w_duty;
      end
    end
  end

  always_comb begin
    w_lvl = 3'd4;
    if (w_duty == '0) begin
      w_lvl = 3'd0;
    end else if (w_duty < c_q1) begin
      w_lvl = 3'd1;
    end else if (w_duty < c_q2) begin
      w_lvl = 3'd2;
    end else if (w_duty < c_q3) begin
      w_lvl = 3'd3;
    end
  end

`ifdef PWM_DEC_FILTER_EN
  typedef enum logic [0:0] {
    S_IDLE      = 1'b0,
    S_CANDIDATE = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cand_q, cand_d;

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    level_d  = level_q;
    change_d = 1'b0;
    if (w_win_end) begin
      case (state_q)
        S_IDLE: begin
          if (w_lvl != level_q) begin
            cand_d  = w_lvl;
            state_d = S_CANDIDATE;
          end
        end
        S_CANDIDATE: begin
          if (w_lvl == cand_q) begin
            level_d  = cand_q;
            change_d = 1'b1;
            state_d  = S_IDLE;
          end else if (w_lvl == level_q) begin
            state_d = S_IDLE;
          end else begin
            cand_d = w_lvl;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      cand_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
    end
  end
`else
  always_comb begin
    level_d  = level_q;
    change_d = 1'b0;
    if (w_win_end) begin
      level_d  = w_lvl;
      change_d = (w_lvl != level_q);
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q     <= 2'b00;
      tick_cnt_q <= '0;
      win_cnt_q  <= '0;
      acc_q      <= '0;
      duty_q     <= '0;
      valid_q    <= 1'b0;
      level_q    <= 3'd0;
      change_q   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], bus.i_pwm};
      tick_cnt_q <= tick_cnt_d;
      win_cnt_q  <= win_cnt_d;
      acc_q      <= acc_d;
      duty_q     <= duty_d;
      valid_q    <= valid_d;
      level_q    <= level_d;
      change_q   <= change_d;
    end
  end

  assign bus.o_duty   = duty_q;
  assign bus.o_valid  = valid_q;
  assign bus.o_level  = level_q;
  assign bus.o_change = change_q;

endmodule
`default_nettype wire

// File: doc/pwm_level_decoder.md
# pwm_level_decoder

Receive-side counterpart of the stand-light PWM output path. Samples a single PWM line (e.g. the LED drive pin or a looped-back copy of it), measures its high time over a fixed window, and reports the brightness level (off, 1–4) plus the raw duty count. Sits on the board-test / self-check path, clocked from the system clock with its own sample-tick divider.

## Interface
- `CLK_DIV`, default 100: system clocks per sample tick (100 MHz → 1 MHz tick); ≥ 2.
- `PERIOD`, default 1024: sample ticks per measurement window. Must be a power of two, ≥ 8. Matches the PWM period.
- `DW`, default 11: duty width. Equals log2(PERIOD)+1.

Ports:
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_pwm`  in  1  asynchronous PWM input.
- `o_duty`  out  DW  high-sample count of the last completed window, 0..PERIOD.
- `o_valid`  out  1  one-clock pulse when `o_duty` updates.
- `o_level`  out  3  decoded level, 0..4.
- `o_change`  out  1  one-clock pulse when `o_level` changes.

## Operation
- Input sync: 2-flop synchronizer on `i_pwm`; only the synchronized value is sampled.
- Tick counter: counts 0..CLK_DIV-1 and wraps. The tick is asserted for one clock when the count is CLK_DIV-1.
- On each tick:
  - Sample the synchronized input; the accumulator adds 1 if high.
  - The window counter advances 0..PERIOD-1 and wraps.
- Window end (tick with window count = PERIOD-1):
  - duty = accumulator + current sample.
  - Latch duty into `o_duty` and pulse `o_valid`.
  - Clear the accumulator to 0 in the same clock. No sample is lost between windows.
- Window phase is arbitrary relative to the PWM; a full-period window gives the same count at any phase.
- Level classification of window duty d (Q = PERIOD/4):
  - d = 0 → 0
  - 1 ≤ d < Q → 1
  - Q ≤ d < 2Q → 2
  - 2Q ≤ d < 3Q → 3
  - d ≥ 3Q → 4; this includes d = PERIOD (always on).
- Level FSM (filter build): states IDLE, CANDIDATE.
  - IDLE: a window level different from `o_level` → store it as the candidate, go to CANDIDATE.
  - CANDIDATE, next window:
    - level equals the candidate → update `o_level`, pulse `o_change`, go to IDLE.
    - level equals `o_level` → go to IDLE.
    - any other level → replace the candidate, stay in CANDIDATE.
- Accumulator never overflows: the max is PERIOD, which fits in DW bits.

## Timing
- Reset values: `o_duty`=0, `o_valid`=0, `o_level`=0, `o_change`=0. Tick, window and accumulator counters = 0, synchronizer flops = 0, FSM = IDLE.
- Input to sampled value: 2 clocks of synchronizer latency.
- `o_valid` and `o_duty` update on the clock after the window-end tick edge, i.e. registered, one clock after the tick.
- `o_level` and `o_change` update in the same clock as the `o_valid` that completes the decision; they never occur without `o_valid`.
- First `o_valid` after reset release: PERIOD·CLK_DIV clocks plus 1.
- Reset asserted mid-window: the partial window is discarded; the next window starts from count 0 after release.
- `i_reset` overrides all other activity in the same clock.

## Configuration
- `PWM_DEC_FILTER_EN` defined: the two-window agreement FSM above is compiled in. A level change needs 2 consecutive agreeing windows, so it is reported at the end of the second window.
- Not defined: FSM removed. `o_level` takes each window's level directly at `o_valid`. `o_change` pulses whenever it differs from the previous value.

## Test plan
All scenarios use `CLK_DIV`=2, `PERIOD`=16, unless stated.
- Reset, `i_pwm`=0 for 3 windows → `o_valid` pulses every 32 clocks; `o_duty`=0; `o_level`=0; `o_change` never pulses.
- Constant `i_pwm`=1 → `o_duty`=16. Filter build: `o_level`=4 with `o_change` at the 2nd window. Non-filter build: at the 1st window.
- PWM with 4 ticks high / 12 ticks low, phase offset 7 ticks → `o_duty`=4 every window; `o_level`=2 (boundary Q=4).
- PWM with 3 ticks high / 13 ticks low → `o_duty`=3, `o_level`=1. Then switch to 12 high / 4 low → `o_duty`=12, `o_level`=4 after 2 windows (filter build).
- Filter build, glitch: steady 8 high (level 3), one window at 1 high, then back to 8 → `o_level` stays 3, no `o_change`.
- Reset asserted mid-window with accumulator at 5, held 1 clock → all outputs 0. Next `o_valid` 32 clocks after release reports the full window only.
